// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Purpose: bundles the fetch-stage, memory-stage and shared-memory signals
//          that connect to mem_arbiter.
// Signals:
//   fetch requester : if_req, if_addr -> if_rdata, if_valid, if_error, f_stall
//   data requester  : dm_read, dm_write, dm_addr, dm_wdata
//                     -> dm_rdata, dm_valid, dm_error, m_stall
//   shared memory   : mem_ack, mem_rdata -> mem_req, mem_we, mem_addr, mem_wdata
// Modports:
//   slave  - the arbiter side (drives the outputs listed above)
//   master - the environment side (requesters plus memory)
interface mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        dm_read;
  logic        dm_write;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        mem_ack;
  logic [79:0] mem_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [79:0] if_rdata;
  logic        if_valid;
  logic        if_error;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        dm_error;
  logic        f_stall;
  logic        m_stall;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, if_error,
           dm_rdata, dm_valid, dm_error, f_stall, m_stall
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, if_error,
           dm_rdata, dm_valid, dm_error, f_stall, m_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose: arbitrates one shared single-port memory between the instruction
//          fetch stage and the data memory stage. Data requests have priority.
//          Each access waits for mem_ack and is aborted after TIMEOUT cycles.
// Parameters:
//   TIMEOUT - cycles mem_req may stay high without mem_ack (1..255)
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mem_arbiter_if.slave carrying all request, response and memory signals
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;

  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [79:0] if_rdata_q;
  logic [63:0] dm_rdata_q;
  logic        if_valid_q;
  logic        if_error_q;
  logic        dm_valid_q;
  logic        dm_error_q;

  logic        latch_en;
  logic        latch_we;
  logic [63:0] latch_addr;
  logic [63:0] latch_wdata;
  logic        if_cap;
  logic        dm_cap;
  logic        if_valid_next;
  logic        if_error_next;
  logic        dm_valid_next;
  logic        dm_error_next;

  // A requester whose completion pulse is high this cycle has not yet dropped
  // its request; treat it as idle so the same access is not issued twice.
  logic        dm_pending;
  logic        if_pending;
  logic        timeout_hit;

  assign dm_pending  = (bus.dm_read | bus.dm_write) & ~dm_valid_q & ~dm_error_q;
  assign if_pending  = bus.if_req & ~if_valid_q & ~if_error_q;
  // Abort once this cycle would be the TIMEOUT-th one without an ack.
  assign timeout_hit = ((wait_cnt + 8'd1) == TIMEOUT_C);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state, latch enables and completion pulses.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    latch_en      = 1'b0;
    latch_we      = we_q;
    latch_addr    = addr_q;
    latch_wdata   = wdata_q;
    if_cap        = 1'b0;
    dm_cap        = 1'b0;
    if_valid_next = 1'b0;
    if_error_next = 1'b0;
    dm_valid_next = 1'b0;
    dm_error_next = 1'b0;
    case (state)
      IDLE: begin
        if (dm_pending && bus.dm_read && bus.dm_write) begin
          // Conflicting read+write: reject without touching memory.
          dm_error_next = 1'b1;
        end else if (dm_pending) begin
          state_next    = DACC;
          wait_cnt_next = 8'd0;
          latch_en      = 1'b1;
          latch_we      = bus.dm_write;
          latch_addr    = bus.dm_addr;
          latch_wdata   = bus.dm_wdata;
        end else if (if_pending) begin
          state_next    = IFETCH;
          wait_cnt_next = 8'd0;
          latch_en      = 1'b1;
          latch_we      = 1'b0;
          latch_addr    = bus.if_addr;
          latch_wdata   = wdata_q;
        end else begin
          state_next = IDLE;
        end
      end
      IFETCH: begin
        if (bus.mem_ack) begin
          if_valid_next = 1'b1;
          if_cap        = 1'b1;
          state_next    = IDLE;
        end else if (timeout_hit) begin
          if_error_next = 1'b1;
          state_next    = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      DACC: begin
        if (bus.mem_ack) begin
          dm_valid_next = 1'b1;
          dm_cap        = ~we_q;
          state_next    = IDLE;
        end else if (timeout_hit) begin
          dm_error_next = 1'b1;
          state_next    = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Access latches, read-data capture and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      if_rdata_q <= 80'd0;
      dm_rdata_q <= 64'd0;
      if_valid_q <= 1'b0;
      if_error_q <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_error_q <= 1'b0;
    end else begin
      if_valid_q <= if_valid_next;
      if_error_q <= if_error_next;
      dm_valid_q <= dm_valid_next;
      dm_error_q <= dm_error_next;
      if (latch_en) begin
        we_q    <= latch_we;
        addr_q  <= latch_addr;
        wdata_q <= latch_wdata;
      end
      if (if_cap) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (dm_cap) begin
        dm_rdata_q <= bus.mem_rdata[63:0];
      end
    end
  end

  assign bus.mem_req   = (state == IFETCH) || (state == DACC);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_error  = if_error_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.dm_error  = dm_error_q;
  assign bus.f_stall   = bus.if_req & ~if_valid_q & ~if_error_q;
  assign bus.m_stall   = (bus.dm_read | bus.dm_write) & ~dm_valid_q & ~dm_error_q;

endmodule
